// File: rtl/lock_pkg.sv
// Shared types, default constants and width helpers for the combination lock.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    OPEN,
    PROG,
    LOCKOUT
  } state_e;

  localparam int unsigned DEF_CODE_LEN    = 6;
  localparam logic [5:0]  DEF_RESET_CODE  = 6'b011001;
  localparam int unsigned DEF_MAX_FAIL    = 3;
  localparam int unsigned DEF_OPEN_CYC    = 500;
  localparam int unsigned DEF_LOCKOUT_CYC = 1000;

  // Bits needed to hold the values 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_edge_det.sv
// Rising-edge detector: one history flop per level input.
module lock_edge_det #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lvl,
  output logic [WIDTH-1:0] rise_c
);

  logic [WIDTH-1:0] lvl_q;

  // Level history, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) lvl_q <= '0;
    else     lvl_q <= lvl;
  end

  assign rise_c = lvl & ~lvl_q;

endmodule

// File: rtl/lock_ctrl.sv
// Combination-lock controller: digit entry, compare, unlock window,
// failed-attempt lockout. Optional macro LOCK_PROG_EN enables in-field
// code reprogramming (PROG state, prog input, prog_mode output).
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned         CODE_LEN    = DEF_CODE_LEN,
  parameter logic [CODE_LEN-1:0] RESET_CODE  = CODE_LEN'(DEF_RESET_CODE),
  parameter int unsigned         MAX_FAIL    = DEF_MAX_FAIL,
  parameter int unsigned         OPEN_CYC    = DEF_OPEN_CYC,
  parameter int unsigned         LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          one,
  input  logic                          zero,
  input  logic                          st,
  input  logic                          prog,
  output logic                          unlock,
  output logic                          alarm,
  output logic                          locked_out,
  output logic                          prog_mode,
  output logic [cnt_w(CODE_LEN)-1:0]    digits,
  output logic [cnt_w(MAX_FAIL)-1:0]    fail_cnt
);

  localparam int unsigned DIG_W  = cnt_w(CODE_LEN);
  localparam int unsigned FAIL_W = cnt_w(MAX_FAIL);
  localparam int unsigned TMR_W  = cnt_w(max_u(OPEN_CYC, LOCKOUT_CYC));

  logic [3:0] rise;
  logic       one_e, zero_e, st_e, prog_e;

  state_e              state, state_d;
  logic [CODE_LEN-1:0] entry, entry_d;
  logic [DIG_W-1:0]    digits_d;
  logic [FAIL_W-1:0]   fail_d, fail_inc;
  logic [TMR_W-1:0]    timer, timer_d;
  logic                pend_val, pend_val_d;
  logic                pend_vld, pend_vld_d;
  logic                poison, poison_d;
  logic                collect;
  logic [CODE_LEN-1:0] code;

  lock_edge_det #(.WIDTH(4)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .lvl    ({prog, st, zero, one}),
    .rise_c (rise)
  );

  assign one_e  = rise[0];
  assign zero_e = rise[1];
  assign st_e   = rise[2];
  assign prog_e = rise[3];

`ifdef LOCK_PROG_EN
  logic [CODE_LEN-1:0] code_d;

  // Programmable code register.
  always_ff @(posedge clk) begin
    if (rst) code <= RESET_CODE;
    else     code <= code_d;
  end
`else
  logic unused_prog;

  assign unused_prog = prog_e;
  assign code        = RESET_CODE;
  assign prog_mode   = 1'b0;
`endif

  // Next-state, datapath and counter updates.
  always_comb begin
    state_d    = state;
    entry_d    = entry;
    digits_d   = digits;
    fail_d     = fail_cnt;
    timer_d    = timer;
    pend_val_d = pend_val;
    pend_vld_d = pend_vld;
    poison_d   = poison;
`ifdef LOCK_PROG_EN
    code_d     = code;
`endif
    fail_inc = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + FAIL_W'(1);
    collect  = (state == IDLE) ||
               (((state == ENTRY) || (state == PROG)) && (digits != DIG_W'(CODE_LEN)));

    // Commit the old pending digit first so a simultaneous press becomes the next one.
    if (collect) begin
      if (st_e && pend_vld) begin
        entry_d    = {entry[CODE_LEN-2:0], pend_val};
        digits_d   = digits + DIG_W'(1);
        pend_vld_d = 1'b0;
      end
      if (one_e && zero_e) begin
        pend_vld_d = 1'b0;
        poison_d   = 1'b1;
      end else if (one_e) begin
        pend_val_d = 1'b1;
        pend_vld_d = 1'b1;
      end else if (zero_e) begin
        pend_val_d = 1'b0;
        pend_vld_d = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (st_e && pend_vld) state_d = ENTRY;
      end
      ENTRY: begin
        if (digits == DIG_W'(CODE_LEN)) begin
          entry_d    = '0;
          digits_d   = '0;
          poison_d   = 1'b0;
          pend_vld_d = 1'b0;
          if ((entry == code) && !poison) begin
            state_d = OPEN;
            fail_d  = '0;
            timer_d = TMR_W'(OPEN_CYC - 1);
          end else begin
            fail_d = fail_inc;
            if (fail_inc == FAIL_W'(MAX_FAIL)) begin
              state_d = LOCKOUT;
              timer_d = TMR_W'(LOCKOUT_CYC - 1);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      OPEN: begin
`ifdef LOCK_PROG_EN
        if (prog_e) begin
          state_d    = PROG;
          timer_d    = TMR_W'(OPEN_CYC - 1);
          entry_d    = '0;
          digits_d   = '0;
          poison_d   = 1'b0;
          pend_vld_d = 1'b0;
        end else
`endif
        if (timer == '0) state_d = IDLE;
        else             timer_d = timer - TMR_W'(1);
      end
`ifdef LOCK_PROG_EN
      PROG: begin
        if (poison || (digits == DIG_W'(CODE_LEN)) || (timer == '0)) begin
          if (!poison && (digits == DIG_W'(CODE_LEN))) code_d = entry;
          state_d    = IDLE;
          entry_d    = '0;
          digits_d   = '0;
          poison_d   = 1'b0;
          pend_vld_d = 1'b0;
        end else begin
          timer_d = timer - TMR_W'(1);
        end
      end
`endif
      LOCKOUT: begin
        if (timer == '0) begin
          state_d = IDLE;
          fail_d  = '0;
        end else begin
          timer_d = timer - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      entry      <= '0;
      digits     <= '0;
      fail_cnt   <= '0;
      timer      <= '0;
      pend_val   <= 1'b0;
      pend_vld   <= 1'b0;
      poison     <= 1'b0;
      unlock     <= 1'b0;
      alarm      <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_d;
      entry      <= entry_d;
      digits     <= digits_d;
      fail_cnt   <= fail_d;
      timer      <= timer_d;
      pend_val   <= pend_val_d;
      pend_vld   <= pend_vld_d;
      poison     <= poison_d;
      unlock     <= (state_d == OPEN);
      alarm      <= (state_d == LOCKOUT) && (state != LOCKOUT);
      locked_out <= (state_d == LOCKOUT);
    end
  end

`ifdef LOCK_PROG_EN
  // PROG indicator.
  always_ff @(posedge clk) begin
    if (rst) prog_mode <= 1'b0;
    else     prog_mode <= (state_d == PROG);
  end
`endif

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl. Outputs packed as
// {unlock, alarm, locked_out, prog_mode, digits[2:0], fail_cnt[1:0]}.
module tb_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst, one, zero, st, prog;
  logic       unlock, alarm, locked_out, prog_mode;
  logic [2:0] digits;
  logic [1:0] fail_cnt;
  int         compared   = 0;
  int         mismatched = 0;

  wire [8:0] outs = {unlock, alarm, locked_out, prog_mode, digits, fail_cnt};

  always #5 clk = ~clk;

  lock_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .one        (one),
    .zero       (zero),
    .st         (st),
    .prog       (prog),
    .unlock     (unlock),
    .alarm      (alarm),
    .locked_out (locked_out),
    .prog_mode  (prog_mode),
    .digits     (digits),
    .fail_cnt   (fail_cnt)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; one = 1'b0; zero = 1'b0; st = 1'b0; prog = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Digit press then store, two cycles; returns just after the commit edge.
  task automatic press_digit(input logic d);
    one = d; zero = ~d;
    tick();
    one = 1'b0; zero = 1'b0; st = 1'b1;
    tick();
    st = 1'b0;
  endtask

  task automatic enter_code(input logic [5:0] c);
    for (int i = 5; i >= 0; i--) press_digit(c[i]);
  endtask

  task automatic btn(input logic o, input logic z, input logic s, input logic p);
    one = o; zero = z; st = s; prog = p;
    tick();
    one = 1'b0; zero = 1'b0; st = 1'b0; prog = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; one = 1'b0; zero = 1'b0; st = 1'b0; prog = 1'b0;
    tick();
    compared++; if (outs !== 9'b0_0_0_0_000_00) begin mismatched++; $display("FAIL reset_hold: got %b exp %b", outs, 9'b0_0_0_0_000_00); end
    rst = 1'b0;
    tick();
    compared++; if (outs !== 9'b0_0_0_0_000_00) begin mismatched++; $display("FAIL reset_idle: got %b exp %b", outs, 9'b0_0_0_0_000_00); end
  endtask

  task automatic test_unlock();
    do_reset();
    enter_code(6'b011001);
    compared++; if (outs !== 9'b0_0_0_0_110_00) begin mismatched++; $display("FAIL unlock_last_commit: got %b exp %b", outs, 9'b0_0_0_0_110_00); end
    tick();
    compared++; if (outs !== 9'b1_0_0_0_000_00) begin mismatched++; $display("FAIL unlock_rise: got %b exp %b", outs, 9'b1_0_0_0_000_00); end
    repeat (499) tick();
    compared++; if (outs !== 9'b1_0_0_0_000_00) begin mismatched++; $display("FAIL unlock_cycle500: got %b exp %b", outs, 9'b1_0_0_0_000_00); end
    tick();
    compared++; if (outs !== 9'b0_0_0_0_000_00) begin mismatched++; $display("FAIL unlock_fall: got %b exp %b", outs, 9'b0_0_0_0_000_00); end
  endtask

  task automatic test_fail_lockout();
    do_reset();
    enter_code(6'b100101); tick();
    compared++; if (outs !== 9'b0_0_0_0_000_01) begin mismatched++; $display("FAIL fail_1: got %b exp %b", outs, 9'b0_0_0_0_000_01); end
    enter_code(6'b100101); tick();
    compared++; if (outs !== 9'b0_0_0_0_000_10) begin mismatched++; $display("FAIL fail_2: got %b exp %b", outs, 9'b0_0_0_0_000_10); end
    enter_code(6'b100101);
    compared++; if (outs !== 9'b0_0_0_0_110_10) begin mismatched++; $display("FAIL fail_3_commit: got %b exp %b", outs, 9'b0_0_0_0_110_10); end
    tick();
    compared++; if (outs !== 9'b0_1_1_0_000_11) begin mismatched++; $display("FAIL lockout_alarm: got %b exp %b", outs, 9'b0_1_1_0_000_11); end
    tick();
    compared++; if (outs !== 9'b0_0_1_0_000_11) begin mismatched++; $display("FAIL lockout_alarm_drop: got %b exp %b", outs, 9'b0_0_1_0_000_11); end
    enter_code(6'b011001);
    compared++; if (outs !== 9'b0_0_1_0_000_11) begin mismatched++; $display("FAIL lockout_ignore_btn: got %b exp %b", outs, 9'b0_0_1_0_000_11); end
    repeat (986) tick();
    compared++; if (outs !== 9'b0_0_1_0_000_11) begin mismatched++; $display("FAIL lockout_cycle1000: got %b exp %b", outs, 9'b0_0_1_0_000_11); end
    tick();
    compared++; if (outs !== 9'b0_0_0_0_000_00) begin mismatched++; $display("FAIL lockout_exit: got %b exp %b", outs, 9'b0_0_0_0_000_00); end
  endtask

  task automatic test_poison();
    do_reset();
    press_digit(1'b0); press_digit(1'b1); press_digit(1'b1);
    compared++; if (outs !== 9'b0_0_0_0_011_00) begin mismatched++; $display("FAIL poison_pre: got %b exp %b", outs, 9'b0_0_0_0_011_00); end
    btn(1'b1, 1'b1, 1'b0, 1'b0);
    compared++; if (outs !== 9'b0_0_0_0_011_00) begin mismatched++; $display("FAIL poison_press: got %b exp %b", outs, 9'b0_0_0_0_011_00); end
    press_digit(1'b0); press_digit(1'b0); press_digit(1'b1);
    tick();
    compared++; if (outs !== 9'b0_0_0_0_000_01) begin mismatched++; $display("FAIL poison_attempt: got %b exp %b", outs, 9'b0_0_0_0_000_01); end
  endtask

  task automatic test_st_overwrite();
    do_reset();
    btn(1'b0, 1'b0, 1'b1, 1'b0);
    compared++; if (outs !== 9'b0_0_0_0_000_00) begin mismatched++; $display("FAIL st_no_digit: got %b exp %b", outs, 9'b0_0_0_0_000_00); end
    btn(1'b1, 1'b0, 1'b0, 1'b0);
    btn(1'b0, 1'b1, 1'b0, 1'b0);
    btn(1'b0, 1'b0, 1'b1, 1'b0);
    compared++; if (outs !== 9'b0_0_0_0_001_00) begin mismatched++; $display("FAIL overwrite_commit: got %b exp %b", outs, 9'b0_0_0_0_001_00); end
    btn(1'b0, 1'b0, 1'b1, 1'b0);
    compared++; if (outs !== 9'b0_0_0_0_001_00) begin mismatched++; $display("FAIL st_after_commit: got %b exp %b", outs, 9'b0_0_0_0_001_00); end
    btn(1'b1, 1'b0, 1'b0, 1'b0);
    btn(1'b1, 1'b0, 1'b0, 1'b0);
    btn(1'b0, 1'b0, 1'b1, 1'b0);
    compared++; if (outs !== 9'b0_0_0_0_010_00) begin mismatched++; $display("FAIL repeat_one: got %b exp %b", outs, 9'b0_0_0_0_010_00); end
    press_digit(1'b1); press_digit(1'b0); press_digit(1'b0); press_digit(1'b1);
    tick();
    compared++; if (outs !== 9'b1_0_0_0_000_00) begin mismatched++; $display("FAIL overwrite_unlock: got %b exp %b", outs, 9'b1_0_0_0_000_00); end
  endtask

`ifdef LOCK_PROG_EN
  task automatic test_prog();
    do_reset();
    enter_code(6'b011001); tick();
    btn(1'b0, 1'b0, 1'b0, 1'b1);
    compared++; if (outs !== 9'b0_0_0_1_000_00) begin mismatched++; $display("FAIL prog_enter: got %b exp %b", outs, 9'b0_0_0_1_000_00); end
    enter_code(6'b111000);
    compared++; if (outs !== 9'b0_0_0_1_110_00) begin mismatched++; $display("FAIL prog_collect: got %b exp %b", outs, 9'b0_0_0_1_110_00); end
    tick();
    compared++; if (outs !== 9'b0_0_0_0_000_00) begin mismatched++; $display("FAIL prog_done: got %b exp %b", outs, 9'b0_0_0_0_000_00); end
    enter_code(6'b011001); tick();
    compared++; if (outs !== 9'b0_0_0_0_000_01) begin mismatched++; $display("FAIL prog_old_code: got %b exp %b", outs, 9'b0_0_0_0_000_01); end
    enter_code(6'b111000); tick();
    compared++; if (outs !== 9'b1_0_0_0_000_00) begin mismatched++; $display("FAIL prog_new_code: got %b exp %b", outs, 9'b1_0_0_0_000_00); end
    repeat (3) tick();
    rst = 1'b1; tick();
    compared++; if (outs !== 9'b0_0_0_0_000_00) begin mismatched++; $display("FAIL reset_mid_open: got %b exp %b", outs, 9'b0_0_0_0_000_00); end
    rst = 1'b0;
    enter_code(6'b011001); tick();
    compared++; if (outs !== 9'b1_0_0_0_000_00) begin mismatched++; $display("FAIL reset_restores_code: got %b exp %b", outs, 9'b1_0_0_0_000_00); end
  endtask

  task automatic test_prog_timeout();
    do_reset();
    enter_code(6'b011001); tick();
    btn(1'b0, 1'b0, 1'b0, 1'b1);
    press_digit(1'b1); press_digit(1'b1); press_digit(1'b1);
    compared++; if (outs !== 9'b0_0_0_1_011_00) begin mismatched++; $display("FAIL prog_partial: got %b exp %b", outs, 9'b0_0_0_1_011_00); end
    repeat (492) tick();
    compared++; if (outs !== 9'b0_0_0_1_011_00) begin mismatched++; $display("FAIL prog_cycle500: got %b exp %b", outs, 9'b0_0_0_1_011_00); end
    tick();
    compared++; if (outs !== 9'b0_0_0_0_000_00) begin mismatched++; $display("FAIL prog_timeout: got %b exp %b", outs, 9'b0_0_0_0_000_00); end
    enter_code(6'b011001); tick();
    compared++; if (outs !== 9'b1_0_0_0_000_00) begin mismatched++; $display("FAIL prog_timeout_code: got %b exp %b", outs, 9'b1_0_0_0_000_00); end
  endtask
`else
  task automatic test_prog_ignored();
    do_reset();
    enter_code(6'b011001); tick();
    btn(1'b0, 1'b0, 1'b0, 1'b1);
    compared++; if (outs !== 9'b1_0_0_0_000_00) begin mismatched++; $display("FAIL prog_ignored: got %b exp %b", outs, 9'b1_0_0_0_000_00); end
  endtask
`endif

  task automatic test_reset_lockout();
    do_reset();
    repeat (3) begin
      enter_code(6'b100101); tick();
    end
    repeat (10) tick();
    compared++; if (outs !== 9'b0_0_1_0_000_11) begin mismatched++; $display("FAIL mid_lockout: got %b exp %b", outs, 9'b0_0_1_0_000_11); end
    rst = 1'b1; tick();
    compared++; if (outs !== 9'b0_0_0_0_000_00) begin mismatched++; $display("FAIL reset_mid_lockout: got %b exp %b", outs, 9'b0_0_0_0_000_00); end
    rst = 1'b0;
    enter_code(6'b011001); tick();
    compared++; if (outs !== 9'b1_0_0_0_000_00) begin mismatched++; $display("FAIL after_lockout_reset: got %b exp %b", outs, 9'b1_0_0_0_000_00); end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_fail_lockout();
    test_poison();
    test_st_overwrite();
`ifdef LOCK_PROG_EN
    test_prog();
    test_prog_timeout();
`else
    test_prog_ignored();
`endif
    test_reset_lockout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
- Synchronous controller that sequences the combination-lock datapath. It collects button-entered digits into an entry register and compares them against a stored code.
- It manages the unlock window, failed-attempt counting, timed lockout and in-field code reprogramming.
- It sits between the front-panel button inputs (one, zero, st, prog) and the actuator/alarm outputs.

Parameters:
- CODE_LEN, 6: number of digits per code.
- RESET_CODE, 6'b011001: code loaded at reset. First digit entered is the MSB.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout.
- OPEN_CYC, 500: cycles unlock stays high. Also used as the PROG-mode timeout.
- LOCKOUT_CYC, 1000: cycles spent in LOCKOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- one  in  1  "1" button, level; rising edge selects digit 1.
- zero  in  1  "0" button, level; rising edge selects digit 0.
- st  in  1  store button; rising edge commits the pending digit.
- prog  in  1  reprogram request; rising edge honoured only in OPEN.
- unlock  out  1  lock actuator, high in OPEN.
- alarm  out  1  one-cycle pulse on entry to LOCKOUT.
- locked_out  out  1  high while in LOCKOUT.
- prog_mode  out  1  high while in PROG.
- digits  out  $clog2(CODE_LEN+1)  digits committed in the current entry.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures.

Behaviour:
- Reset (rst high at clk edge):
  - state=IDLE; code=RESET_CODE; entry=0; pending invalid.
  - All outputs 0, including digits and fail_cnt.
  - Edge-detect history registers are cleared to 0.
  - Reset mid-entry, mid-OPEN or mid-LOCKOUT aborts immediately.
- Edge detection: each input is registered once. edge = in & ~in_q.
- Pending digit:
  - Rising edge of one sets pending=1, valid.
  - Rising edge of zero sets pending=0, valid.
  - Both edges in the same cycle: pending invalid, poison flag set for this entry.
  - A later one/zero edge before st overwrites the pending digit.
- Commit:
  - st edge with valid pending shifts pending into the entry LSB, increments digits and clears valid.
  - st edge with no valid pending is ignored.
  - A one/zero edge in the same cycle as st becomes the pending digit for the next st; the st commits the old pending digit.
- States:
  - IDLE: first commit moves to ENTRY.
  - ENTRY: when digits reaches CODE_LEN, compare on the next cycle.
    - Match and no poison: go to OPEN; fail_cnt=0.
    - Otherwise: fail_cnt+1. If the new value equals MAX_FAIL, go to LOCKOUT; else go to IDLE.
    - On exit from ENTRY: digits=0, entry=0, poison=0.
  - OPEN: unlock=1 for exactly OPEN_CYC cycles, then IDLE. A prog edge goes to PROG and the timer is reloaded.
  - PROG: prog_mode=1. Digits are collected the same way as in ENTRY.
    - After CODE_LEN commits without poison, code<=entry and go to IDLE.
    - Poison, or timer expiry, aborts to IDLE with the old code retained.
  - LOCKOUT: alarm is pulsed on the entry cycle; locked_out=1. All buttons are ignored and the edge history still updates. After LOCKOUT_CYC cycles: fail_cnt=0, go to IDLE.
- Latency: st sampled high at cycle n → digit committed at end of n.
  - If that is the final digit, the compare happens in n+1 and unlock is high from n+2.
- fail_cnt saturates at MAX_FAIL. Timers are down-counters sized $clog2(max(OPEN_CYC,LOCKOUT_CYC)+1).

Optional Feature:
- LOCK_PROG_EN defined: PROG state, the prog port behaviour and prog_mode are as above.
- Undefined:
  - prog is ignored, prog_mode is tied 0, PROG state is absent.
  - code is the constant RESET_CODE with no code register.

Decomposition:
- Package lock_pkg holds:
  - the state enum {IDLE, ENTRY, OPEN, PROG, LOCKOUT};
  - default CODE_LEN/OPEN_CYC/LOCKOUT_CYC constants;
  - width helper functions.
- Sub-module lock_edge_det (WIDTH parameter): registers a vector of level inputs and outputs rising-edge pulses. It is instantiated once for {one, zero, st, prog}.

Test Plan:
- rst, then enter 0,1,1,0,0,1 (each digit then st) → unlock rises 2 cycles after the last st edge and stays high 500 cycles; fail_cnt=0.
- Enter 1,0,0,1,0,1 three times → fail_cnt goes 1 then 2. On the third failure: alarm pulses 1 cycle, locked_out=1 for 1000 cycles, buttons ignored, then IDLE with fail_cnt=0.
- Press one and zero in the same cycle during an otherwise correct entry → attempt fails and fail_cnt=1.
- st with no digit pressed → digits unchanged. A repeated one before st → only the last digit is committed.
- LOCK_PROG_EN:
  - Open the lock, pulse prog, enter 1,1,1,0,0,0 → prog_mode drops.
  - Old code 011001 now fails; 111000 unlocks.
  - Unsupported PROG timeout after 500 cycles → code unchanged.
- Assert rst mid-OPEN and mid-LOCKOUT → next cycle all outputs are 0 and code=RESET_CODE.
